// File: rtl/mul_wb_unit.sv
// mul_wb_unit: iterative radix-2 MUL/UMULL/SMULL unit that writes Rd/Ra through
// register-file write ports 3 and 4.
module mul_wb_unit #(
  parameter int WIDTH = 32,
  parameter int AW = 4,
  parameter int CW = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic [1:0] op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [AW-1:0] rd_addr,
  input  logic [AW-1:0] ra_addr,
  output logic busy,
  output logic done,
  output logic we3,
  output logic [AW-1:0] wa3,
  output logic [WIDTH-1:0] wd3,
  output logic we4,
  output logic [AW-1:0] wa4,
  output logic [WIDTH-1:0] wd4,
  output logic flag_n,
  output logic flag_z
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, WB = 2'd3;
  logic [1:0] state_q, state_d;
  logic long_q, neg_q;
  logic [AW-1:0] rd_q, ra_q, wa3_q, wa4_q;
  logic [WIDTH-1:0] a_q, hi_q, lo_q, wd3_q, wd4_q;
  logic [CW-1:0] cnt_q;
  logic fn_q, fz_q;
  logic smull;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    smull = op == 2'b10;
    abs_a = (smull && srca[WIDTH-1]) ? -srca : srca;
    abs_b = (smull && srcb[WIDTH-1]) ? -srcb : srcb;
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    state_d = state_q == IDLE ? (start ? CALC : IDLE) :
              state_q == CALC ? (cnt_q == CW'(WIDTH - 1) ? FIX : CALC) :
              state_q == FIX ? WB : IDLE;
  end
  // {hi_q, lo_q} starts as {0, multiplier}; each step adds and shifts right one bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      long_q <= 1'b0;
      neg_q <= 1'b0;
      rd_q <= '0;
      ra_q <= '0;
      a_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      cnt_q <= '0;
      wa3_q <= '0;
      wa4_q <= '0;
      wd3_q <= '0;
      wd4_q <= '0;
      fn_q <= 1'b0;
      fz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        long_q <= op == 2'b01 || op == 2'b10;
        neg_q <= smull && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
        rd_q <= rd_addr;
        ra_q <= ra_addr;
        a_q <= abs_a;
        hi_q <= '0;
        lo_q <= abs_b;
        cnt_q <= '0;
      end else if (state_q == CALC) begin
        {hi_q, lo_q} <= {sum, lo_q[WIDTH-1:1]};
        cnt_q <= cnt_q + CW'(1);
      end else if (state_q == FIX) begin
        wa3_q <= rd_q;
        wd3_q <= prod[WIDTH-1:0];
        wa4_q <= long_q ? ra_q : wa4_q;
        wd4_q <= long_q ? prod[2*WIDTH-1:WIDTH] : '0;
        fn_q <= long_q ? prod[2*WIDTH-1] : prod[WIDTH-1];
        fz_q <= long_q ? prod == '0 : prod[WIDTH-1:0] == '0;
      end
    end
  end
  // a long op targeting one register writes only the high word
  assign busy = state_q != IDLE;
  assign done = state_q == WB;
  assign we3 = done && !(long_q && rd_q == ra_q);
  assign we4 = done && long_q;
  assign wa3 = wa3_q;
  assign wd3 = wd3_q;
  assign wa4 = wa4_q;
  assign wd4 = wd4_q;
  assign flag_n = fn_q;
  assign flag_z = fz_q;
endmodule

// File: tb/tb_mul_wb_unit.sv
// tb_mul_wb_unit: randomized and directed checks of mul_wb_unit against a
// cycle-level arithmetic reference model.
module tb_mul_wb_unit;
  logic clk = 1'b0;
  logic reset_n, start;
  logic [1:0] op;
  logic [31:0] srca, srcb, wd3, wd4;
  logic [3:0] rd_addr, ra_addr, wa3, wa4;
  logic busy, done, we3, we4, flag_n, flag_z;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, m_k = 0;
  logic m_act = 1'b0, m_long = 1'b0, m_we3 = 1'b0;
  logic [63:0] m_p = '0;
  logic [3:0] m_rd = '0, m_ra = '0;

  mul_wb_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .rd_addr(rd_addr), .ra_addr(ra_addr), .busy(busy), .done(done),
    .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
    .flag_n(flag_n), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o == 2'b10) return 64'(longint'($signed(a)) * longint'($signed(b)));
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Reference: an op accepted at edge k writes back in the cycle after edge k+33;
  // the unit is idle again for a start sampled at edge k+35 or later.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_act <= 1'b0;
    else begin
      cyc <= cyc + 1;
      if (start && (!m_act || cyc + 1 >= m_k + 35)) begin
        m_act <= 1'b1;
        m_k <= cyc + 1;
        m_long <= op == 2'b01 || op == 2'b10;
        m_we3 <= !((op == 2'b01 || op == 2'b10) && rd_addr == ra_addr);
        m_p <= ref_prod(op, srca, srcb);
        m_rd <= rd_addr;
        m_ra <= ra_addr;
      end
    end
  end

  always @(negedge clk) begin
    logic wb;
    if (!reset_n) begin
      chk("rst_ctrl", {busy, done, we3, we4, flag_n, flag_z, wa3, wa4}, 0);
      chk("rst_data", {wd3, wd4}, 0);
    end else begin
      wb = m_act && cyc == m_k + 33;
      chk("busy", busy, m_act && cyc <= m_k + 33);
      chk("done", done, wb);
      chk("we3", we3, wb && m_we3);
      chk("we4", we4, wb && m_long);
      if (wb) begin
        if (m_we3) begin
          chk("wa3", wa3, m_rd);
          chk("wd3", wd3, m_p[31:0]);
        end
        if (m_long) chk("wa4", wa4, m_ra);
        chk("wd4", wd4, m_long ? m_p[63:32] : 64'd0);
        chk("flag_n", flag_n, m_long ? m_p[63] : m_p[31]);
        chk("flag_z", flag_z, m_long ? m_p == 0 : m_p[31:0] == 0);
      end
    end
  end

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] rd, input logic [3:0] ra, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    op = o; srca = a; srcb = b; rd_addr = rd; ra_addr = ra; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); srca = $urandom; srcb = $urandom;
    rd_addr = 4'($urandom); ra_addr = 4'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("run_done_seen", done, 1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, nd;
    logic [3:0] r;
    reset_n = 1'b0; start = 1'b0; op = '0; srca = '0; srcb = '0; rd_addr = '0; ra_addr = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    run(2'b00, 32'd7, 32'd6, 4'd2, 4'd9, lat);
    chk("mul_latency", lat, 34);
    chk("mul_we3", we3, 1); chk("mul_wa3", wa3, 2); chk("mul_wd3", wd3, 32'h2A);
    chk("mul_we4", we4, 0); chk("mul_wd4", wd4, 0); chk("mul_fz", flag_z, 0);
    @(negedge clk);
    chk("mul_done_width", done, 0);
    run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, 4'd3, lat);
    chk("umull_wd3", wd3, 32'h1); chk("umull_wd4", wd4, 32'hFFFFFFFE);
    chk("umull_we", {we3, we4}, 2'b11); chk("umull_wa4", wa4, 3); chk("umull_fn", flag_n, 1);
    run(2'b10, 32'hFFFFFFFE, 32'd3, 4'd4, 4'd7, lat);
    chk("smull_neg_wd3", wd3, 32'hFFFFFFFA); chk("smull_neg_wd4", wd4, 32'hFFFFFFFF);
    chk("smull_neg_fn", flag_n, 1);
    run(2'b10, 32'h80000000, 32'h80000000, 4'd4, 4'd7, lat);
    chk("smull_min_wd4", wd4, 32'h40000000); chk("smull_min_wd3", wd3, 0); chk("smull_min_fn", flag_n, 0);
    run(2'b01, 32'h0, 32'h1234, 4'd6, 4'd8, lat);
    chk("umull_zero_wd", {wd3, wd4}, 0); chk("umull_zero_fz", flag_z, 1);
    run(2'b01, 32'h10000, 32'h30000, 4'd5, 4'd5, lat);
    chk("same_reg_we3", we3, 0); chk("same_reg_we4", we4, 1);
    chk("same_reg_wa4", wa4, 5); chk("same_reg_wd4", wd4, 32'h3);
    run(2'b11, 32'h10000, 32'h10000, 4'd3, 4'd2, lat);
    chk("mul_rsv_wd3", wd3, 0); chk("mul_rsv_fz", flag_z, 1); chk("mul_rsv_we4", we4, 0);
    run(2'b00, 32'hFFFFFFFF, 32'd2, 4'd1, 4'd2, lat);
    chk("mul_fn_wd3", wd3, 32'hFFFFFFFE); chk("mul_fn", flag_n, 1);

    // start re-pulsed during CALC and in the WB cycle must not start a second op
    @(negedge clk);
    while (busy) @(negedge clk);
    op = 2'b00; srca = 32'd3; srcb = 32'd4; rd_addr = 4'd1; ra_addr = 4'd2; start = 1'b1;
    nd = 0;
    for (int i = 1; i <= 44; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        chk("repulse_wd3", wd3, 32'd12);
        chk("repulse_latency", i, 34);
      end
      start = (i == 3 || i == 20 || i == 33);
      srca = $urandom; srcb = $urandom; op = 2'($urandom);
    end
    chk("repulse_done_count", nd, 1);
    run(2'b01, 32'd100000, 32'd300000, 4'd9, 4'd10, lat);
    chk("after_repulse_wd3", wd3, 32'hFC23AC00); chk("after_repulse_wd4", wd4, 32'h6);

    // asynchronous reset in the middle of CALC aborts without a write
    @(negedge clk);
    while (busy) @(negedge clk);
    op = 2'b01; srca = 32'd7; srcb = 32'd9; rd_addr = 4'd4; ra_addr = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {busy, done, we3, we4, flag_n, flag_z}, 0);
    chk("async_rst_addr", {wa3, wa4}, 0);
    chk("async_rst_data", {wd3, wd4}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || we3 || we4) nd++;
    end
    chk("abort_no_write", nd, 0);
    run(2'b00, 32'd5, 32'd5, 4'd3, 4'd0, lat);
    chk("post_rst_wd3", wd3, 32'd25); chk("post_rst_we3", we3, 1);

    for (int t = 0; t < 30; t++) begin
      r = 4'($urandom);
      run(2'($urandom), pick(), pick(), r, ($urandom_range(0, 3) == 0) ? r : 4'($urandom), lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end
endmodule
